pll_reset_sequencer: RTL

//  Supervises a multi-output system PLL from the free-running reference clock. Pulses the PLL reset and

---
 rtl/pll_reset_sequencer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL reset pulse, lock qualification, retry/fault and staggered domain reset release
module pll_reset_sequencer #(
  parameter int NUM_CLOCKS          = 3,
  parameter int RESET_PULSE_CYCLES  = 16,
  parameter int LOCK_STABLE_CYCLES  = 256,
  parameter int LOCK_TIMEOUT_CYCLES = 4096,
  parameter int STAGGER_CYCLES      = 8,
  parameter int MAX_RETRIES         = 3
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  input  logic                  pll_locked,
  input  logic                  relock_req,
  output logic                  pll_rst,
  output logic [NUM_CLOCKS-1:0] domain_rst_n,
  output logic                  all_ready,
  output logic                  fault,
  output logic [7:0]            relock_count,
  output logic [2:0]            state
);

  localparam int PW = $clog2(RESET_PULSE_CYCLES + 1);
  localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(STAGGER_CYCLES + 1);
  localparam int RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

  localparam logic [PW-1:0] PULSE_N   = PW'(RESET_PULSE_CYCLES);
  localparam logic [SW-1:0] STABLE_N  = SW'(LOCK_STABLE_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_N = TW'(LOCK_TIMEOUT_CYCLES);
  localparam logic [GW-1:0] STAGGER_N = GW'(STAGGER_CYCLES);
  localparam logic [RW-1:0] RETRY_N   = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_RELEASE   = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            sync_q;
  logic [PW-1:0]         pulse_q, pulse_d;
  logic [SW-1:0]         stable_q, stable_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [GW-1:0]         stag_q, stag_d;
  logic [RW-1:0]         retry_q, retry_d;
  logic                  pll_rst_q, pll_rst_d;
  logic [NUM_CLOCKS-1:0] dom_q, dom_d;
  logic                  ready_q, ready_d;
  logic                  fault_q, fault_d;
  logic [7:0]            rcnt_q, rcnt_d;

  logic                  lock_s;
  logic [PW-1:0]         pulse_inc;
  logic [SW-1:0]         stable_nxt;
  logic [TW-1:0]         tmo_inc;
  logic [GW-1:0]         stag_inc;
  logic [NUM_CLOCKS-1:0] dom_next;

  assign lock_s     = sync_q[1];
  assign pulse_inc  = pulse_q + 1'b1;
  assign stable_nxt = lock_s ? stable_q + 1'b1 : '0;
  assign tmo_inc    = tmo_q + 1'b1;
  assign stag_inc   = stag_q + 1'b1;
  // Released domains form a thermometer code; each release shifts in one more bit.
  assign dom_next   = (dom_q << 1) | NUM_CLOCKS'(1);

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state_q   <= S_PLL_RST;
      sync_q    <= '0;
      pulse_q   <= '0;
      stable_q  <= '0;
      tmo_q     <= '0;
      stag_q    <= '0;
      retry_q   <= '0;
      pll_rst_q <= 1'b1;
      dom_q     <= '0;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
      rcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[0], pll_locked};
      pulse_q   <= pulse_d;
      stable_q  <= stable_d;
      tmo_q     <= tmo_d;
      stag_q    <= stag_d;
      retry_q   <= retry_d;
      pll_rst_q <= pll_rst_d;
      dom_q     <= dom_d;
      ready_q   <= ready_d;
      fault_q   <= fault_d;
      rcnt_q    <= rcnt_d;
    end
  end

  // Per-state counters default to zero so every state entry starts them clean.
  always_comb begin
    state_d   = state_q;
    pulse_d   = '0;
    stable_d  = '0;
    tmo_d     = '0;
    stag_d    = '0;
    retry_d   = retry_q;
    pll_rst_d = pll_rst_q;
    dom_d     = dom_q;
    ready_d   = ready_q;
    fault_d   = fault_q;
    rcnt_d    = rcnt_q;
    if (relock_req) begin
      state_d   = S_PLL_RST;
      pll_rst_d = 1'b1;
      dom_d     = '0;
      ready_d   = 1'b0;
      fault_d   = 1'b0;
      retry_d   = '0;
    end else begin
      case (state_q)
        S_PLL_RST: begin
          pulse_d = pulse_inc;
          if (pulse_inc == PULSE_N) begin
            state_d   = S_WAIT_LOCK;
            pulse_d   = '0;
            pll_rst_d = 1'b0;
          end
        end
        S_WAIT_LOCK: begin
          stable_d = stable_nxt;
          tmo_d    = tmo_inc;
          if (stable_nxt == STABLE_N) begin
            stable_d = '0;
            tmo_d    = '0;
            dom_d    = dom_next;
            if (dom_next[NUM_CLOCKS-1]) begin
              state_d = S_RUN;
              ready_d = 1'b1;
              retry_d = '0;
            end else begin
              state_d = S_RELEASE;
            end
          end else if (tmo_inc == TIMEOUT_N) begin
            stable_d  = '0;
            tmo_d     = '0;
            pll_rst_d = 1'b1;
            if (retry_q < RETRY_N) begin
              retry_d = retry_q + 1'b1;
              state_d = S_PLL_RST;
            end else begin
              state_d = S_FAULT;
              fault_d = 1'b1;
            end
          end
        end
        S_RELEASE, S_RUN: begin
          if (!lock_s) begin
            state_d   = S_PLL_RST;
            pll_rst_d = 1'b1;
            dom_d     = '0;
            ready_d   = 1'b0;
            if (rcnt_q != 8'hFF) rcnt_d = rcnt_q + 8'd1;
          end else if (state_q == S_RELEASE) begin
            stag_d = stag_inc;
            if (stag_inc == STAGGER_N) begin
              stag_d = '0;
              dom_d  = dom_next;
              if (dom_next[NUM_CLOCKS-1]) begin
                state_d = S_RUN;
                ready_d = 1'b1;
                retry_d = '0;
              end
            end
          end
        end
        S_FAULT: begin
        end
        default: begin
          state_d   = S_PLL_RST;
          pll_rst_d = 1'b1;
          dom_d     = '0;
          ready_d   = 1'b0;
        end
      endcase
    end
  end

  assign pll_rst      = pll_rst_q;
  assign domain_rst_n = dom_q;
  assign all_ready    = ready_q;
  assign fault        = fault_q;
  assign relock_count = rcnt_q;
  assign state        = state_q;

endmodule
